key_schedule_128: RTL and testbench
===================================

Name: key_schedule_128

Overview:
Sequential AES-128 key-expansion controller that drives the registered g_function stage and consumes its substituted word. Each round it presents word 3 of the current round key and the round constant, waits out the g_function latency, then XOR-chains the result into the next round key. It emits round keys 0..10 one at a time over a valid/ready interface to the encryption datapath.

Parameters:
G_LAT, 1, cycles from word_3/round_number applied to word_3_substituted valid (registered S_box latency of g_function)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
key_in  input  128  cipher key, w0 = key_in[127:96] ... w3 = key_in[31:0]; sampled on start accept
start  input  1  request expansion; accepted only when ready=1
ready  output  1  high in IDLE only
rkey_out  output  128  current round key, same word order as key_in
rkey_idx  output  4  round index 0..10 of rkey_out
rkey_valid  output  1  rkey_out/rkey_idx valid
rkey_ready  input  1  downstream accepts round key
done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=1, rkey_valid=0, done=0, rkey_out=0, rkey_idx=0, rcon=8'h01, wait counter=0.
- Internal regs: cur_key[127:0], idx[3:0], rcon[7:0], wait counter sized for G_LAT.
- g_function instance: word_3=cur_key[31:0], round_number=rcon, same clk/rst; output g[31:0] = SubWord(RotWord(w3)) with rcon XORed into the MSB byte.
- IDLE: ready=1. start=1 -> latch cur_key=key_in, idx=0, rcon=8'h01, go EMIT. start=0 or ready=0 -> ignored.
- EMIT: rkey_valid=1, rkey_out=cur_key, rkey_idx=idx. Output holds stable while rkey_ready=0 (no timeout).
  - Handshake with idx=10 -> IDLE, done=1 for the next cycle, ready=1 in that same cycle.
  - Handshake with idx<10 -> SUB, wait counter cleared.
- SUB: rkey_valid=0. Hold cur_key and rcon stable for G_LAT cycles, then go COMBINE.
- COMBINE (1 cycle):
  - w4=w0^g, w5=w1^w4, w6=w2^w5, w7=w3^w6.
  - cur_key <= {w4,w5,w6,w7}, idx <= idx+1.
  - rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Go EMIT.
- rcon sequence used for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- Timing with rkey_ready held high and G_LAT=1:
  - start accepted at cycle 0; key k0 valid at cycle 1.
  - Key kn valid at cycle 1+3n; k10 valid at cycle 31.
  - done=1 at cycle 32.
  - Round period is G_LAT+2 cycles.
- Backpressure adds cycles only in EMIT; key values are unchanged.
- start while not IDLE: ignored, with no effect on the running expansion.
- start in the done cycle: accepted, since ready=1 there.
- Reset mid-operation: immediate return to reset values; a partial schedule is never resumed.
- done and rkey_valid are never high in the same cycle.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rkey_ready=1 -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx2 = f2c295f27a96b9435935807a7359f67f, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 (valid at cycle 31); done at cycle 32.
- All-zero key -> idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rkey_ready stalls (0..5 cycles) on the FIPS key -> identical 11 keys in order; rkey_out/rkey_idx stable during every stall; done occurs exactly once.
- start pulsed in idx 4 EMIT and in SUB -> ignored, with keys still matching FIPS. start in the done cycle with the zero key -> the new schedule begins, k0 = 0 at the next cycle.
- rst low during the SUB of round 6 -> ready=1, rkey_valid=0, outputs zero. A following start with the FIPS key reproduces the full correct schedule, with rcon restarting at 01.
- Scoreboard check of rcon via idx1..10 against a reference model, plus an assertion that rkey_valid is 0 in SUB and COMBINE.

Source files
------------

// File: rtl/key_schedule_128.sv
// AES-128 key expansion controller.
// g_function computes SubWord(RotWord(w3)) ^ {rcon, 24'h0} through a registered
// S-box pipeline of G_LAT stages. key_schedule_128 walks rounds 0..10. For each
// round it emits the current round key over a valid/ready handshake, waits out
// the g_function latency, and XOR-chains the result into the next round key.

module g_function #(
  parameter int G_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_3,
  input  logic [7:0]  round_number,
  output logic [31:0] word_3_substituted
);

  // Forward AES S-box. Entry i sits at index i, so row 0 is entries 00..0f.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [31:0]             rot_word;
  logic [31:0]             sub_word;
  logic [31:0]             g_comb;
  logic [G_LAT-1:0][31:0]  pipe_reg;

  // RotWord: bytes b0 b1 b2 b3 become b1 b2 b3 b0.
  assign rot_word = {word_3[23:0], word_3[31:24]};

  // SubWord: one S-box lookup per byte lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub_byte
      assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
    end
  endgenerate

  // The round constant only touches the most significant byte.
  assign g_comb = sub_word ^ {round_number, 24'h000000};

  // First stage registers the S-box result; later stages are plain delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg[0] <= g_comb;
      for (int i = 1; i < G_LAT; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  assign word_3_substituted = pipe_reg[G_LAT-1];

endmodule

module key_schedule_128 #(
  parameter int G_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic         ready,
  output logic [127:0] rkey_out,
  output logic [3:0]   rkey_idx,
  output logic         rkey_valid,
  input  logic         rkey_ready,
  output logic         done
);

  localparam int                WAIT_W    = (G_LAT > 1) ? $clog2(G_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(G_LAT - 1);
  localparam logic [3:0]        LAST_IDX  = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT    = 2'd1,
    SUB     = 2'd2,
    COMBINE = 2'd3
  } state_t;

  state_t              state_reg;
  logic [127:0]        cur_key_reg;
  logic [3:0]          idx_reg;
  logic [7:0]          rcon_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;

  logic [31:0]         g_word;
  logic [31:0]         w4, w5, w6, w7;
  logic [127:0]        key_next;
  logic [7:0]          rcon_next;
  logic [3:0]          idx_next;

  // g_function always looks at the live w3/rcon. Both stay frozen from COMBINE
  // until the next COMBINE, so its output has settled before it is consumed.
  g_function #(
    .G_LAT (G_LAT)
  ) u_g_function (
    .clk                (clk),
    .rst                (rst),
    .word_3             (cur_key_reg[31:0]),
    .round_number       (rcon_reg),
    .word_3_substituted (g_word)
  );

  // Next round key: each new word chains off the one just produced.
  assign w4       = cur_key_reg[127:96] ^ g_word;
  assign w5       = cur_key_reg[95:64]  ^ w4;
  assign w6       = cur_key_reg[63:32]  ^ w5;
  assign w7       = cur_key_reg[31:0]   ^ w6;
  assign key_next = {w4, w5, w6, w7};

  // xtime in GF(2^8), reducing by the AES polynomial on overflow.
  assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1B : 8'h00);
  assign idx_next  = idx_reg + 4'd1;

  // Controller FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cur_key_reg  <= '0;
      idx_reg      <= '0;
      rcon_reg     <= 8'h01;
      wait_cnt_reg <= '0;
      ready        <= 1'b1;
      rkey_valid   <= 1'b0;
      rkey_out     <= '0;
      rkey_idx     <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && ready) begin
            cur_key_reg <= key_in;
            idx_reg     <= 4'd0;
            rcon_reg    <= 8'h01;
            rkey_out    <= key_in;
            rkey_idx    <= 4'd0;
            rkey_valid  <= 1'b1;
            ready       <= 1'b0;
            state_reg   <= EMIT;
          end
        end

        EMIT: begin
          // Output holds untouched until the downstream side takes it.
          if (rkey_valid && rkey_ready) begin
            rkey_valid <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              done      <= 1'b1;
              ready     <= 1'b1;
              state_reg <= IDLE;
            end else begin
              wait_cnt_reg <= '0;
              state_reg    <= SUB;
            end
          end
        end

        SUB: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            state_reg <= COMBINE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        COMBINE: begin
          cur_key_reg <= key_next;
          idx_reg     <= idx_next;
          rcon_reg    <= rcon_next;
          rkey_out    <= key_next;
          rkey_idx    <= idx_next;
          rkey_valid  <= 1'b1;
          state_reg   <= EMIT;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_128.sv
// Bench for key_schedule_128. Stimulus pushes the expected round keys into a
// scoreboard queue. A negedge monitor pops one entry for each accepted round key.
module tb_key_schedule_128;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         start = 1'b0;
  logic         ready;
  logic [127:0] rkey_out;
  logic [3:0]   rkey_idx;
  logic         rkey_valid;
  logic         rkey_ready = 1'b1;
  logic         done;

  key_schedule_128 dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .start      (start),
    .ready      (ready),
    .rkey_out   (rkey_out),
    .rkey_idx   (rkey_idx),
    .rkey_valid (rkey_valid),
    .rkey_ready (rkey_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [127:0] fips_keys [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [127:0] zero_keys [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  int   done_count = 0;
  int   k10_cyc    = -1;
  logic stall_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, and valid/done exclusivity.
  logic         prev_hold = 1'b0;
  logic [127:0] prev_key  = '0;
  logic [3:0]   prev_idx  = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_hold) begin
        check("stall_valid", rkey_valid, 1);
        check("stall_key", rkey_out, prev_key);
        check("stall_idx", rkey_idx, prev_idx);
      end
      if (dut.state_reg == 2'd2 || dut.state_reg == 2'd3)
        check("valid_low_in_sub_combine", rkey_valid, 0);
      if (done) begin
        done_count++;
        check("done_excludes_valid", rkey_valid, 0);
      end
      if (rkey_valid && rkey_ready) begin
        $display("[TB] cycle %0d key idx %0d = %h", cyc, rkey_idx, rkey_out);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_key: got idx %0d, expected no key", rkey_idx);
        end else begin
          mon_e = exp_q.pop_front();
          check("rkey_idx", rkey_idx, mon_e.idx);
          check("rkey_out", rkey_out, mon_e.key);
        end
        if (rkey_idx == 4'd10) k10_cyc = cyc;
      end
      prev_hold = rkey_valid && !rkey_ready;
      prev_key  = rkey_out;
      prev_idx  = rkey_idx;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Downstream ready: when enabled, every fresh round key is held off 0..5 cycles.
  initial begin
    int left;
    left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_en) begin
        rkey_ready = 1'b1;
      end else if (left > 0) begin
        rkey_ready = 1'b0;
        left--;
      end else begin
        rkey_ready = 1'b1;
        left = $urandom_range(0, 5);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input bit zero_tbl);
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.idx = 4'(i);
      e.key = zero_tbl ? zero_keys[i] : fips_keys[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic launch(input logic [127:0] key, input bit zero_tbl, output int start_c);
    push_exp(zero_tbl);
    check("ready_before_start", ready, 1);
    k10_cyc = -1;
    key_in  = key;
    start   = 1'b1;
    start_c = cyc;
    step();
    start   = 1'b0;
    key_in  = {4{32'hdeadbeef}};
  endtask

  task automatic wait_done(output int done_c);
    done_c = -1;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        done_c = cyc;
        break;
      end
      step();
    end
    if (done_c < 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout: got no done, expected done within 1000 cycles");
    end
  endtask

  task automatic wait_key(input logic [3:0] idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rkey_valid && rkey_idx == idx) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL key_wait_timeout: got no idx %0d, expected it presented", idx);
    end
  endtask

  initial begin
    int s, d, dc0;

    // Reset values while rst is held low.
    step();
    step();
    check("reset_ready", ready, 1);
    check("reset_valid", rkey_valid, 0);
    check("reset_done", done, 0);
    check("reset_rkey_out", rkey_out, 0);
    check("reset_rkey_idx", rkey_idx, 0);
    rst = 1'b1;
    step();

    // FIPS key, no backpressure: k10 at cycle 31 and done at cycle 32.
    dc0 = done_count;
    launch(fips_keys[0], 1'b0, s);
    wait_done(d);
    check("fips_k10_cycle", 128'(k10_cyc - s), 128'd31);
    check("fips_done_cycle", 128'(d - s), 128'd32);
    check("done_ready_same_cycle", ready, 1);

    // Back-to-back start in the done cycle with the all-zero key.
    launch(128'h0, 1'b1, s);
    check("chain_k0_valid", rkey_valid, 1);
    check("chain_k0_idx", rkey_idx, 0);
    check("chain_k0_key", rkey_out, 0);
    wait_done(d);
    step();
    step();
    check("two_runs_two_dones", 128'(done_count - dc0), 128'd2);
    check("queue_empty_zero", 128'(exp_q.size()), 128'd0);

    // Random backpressure on the FIPS key.
    stall_en = 1'b1;
    dc0 = done_count;
    launch(fips_keys[0], 1'b0, s);
    wait_done(d);
    stall_en = 1'b0;
    step();
    step();
    step();
    check("stall_done_once", 128'(done_count - dc0), 128'd1);
    check("queue_empty_stall", 128'(exp_q.size()), 128'd0);

    // Stray start during idx 4 EMIT and the SUB that follows.
    launch(fips_keys[0], 1'b0, s);
    wait_key(4'd4);
    start  = 1'b1;
    key_in = {4{32'h5a5a5a5a}};
    step();
    check("busy_ready_low", ready, 0);
    step();
    start  = 1'b0;
    wait_done(d);
    step();
    check("queue_empty_ignore", 128'(exp_q.size()), 128'd0);

    // Reset during the SUB that follows round key 6.
    launch(fips_keys[0], 1'b0, s);
    wait_key(4'd6);
    step();
    check("in_sub_before_reset", 128'(dut.state_reg), 128'd2);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_ready", ready, 1);
    check("midrst_valid", rkey_valid, 0);
    check("midrst_done", done, 0);
    check("midrst_rkey_out", rkey_out, 0);
    check("midrst_rkey_idx", rkey_idx, 0);
    step();
    step();
    rst = 1'b1;
    step();
    launch(fips_keys[0], 1'b0, s);
    wait_done(d);
    check("post_rst_k10_cycle", 128'(k10_cyc - s), 128'd31);
    check("post_rst_done_cycle", 128'(d - s), 128'd32);
    step();
    check("queue_empty_post_rst", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
